// File: rtl/seed_serial_adder.sv
// seed_serial_adder
//
// Byte-serial modular adder for the 8-bit SEED datapath. Computes
// A + B mod 2^(8*NUM_BYTES), taking one operand byte pair per accepted
// beat, LSB-first. The carry between bytes is kept in a flop, and one
// registered sum byte is produced per beat. The key schedule uses it for
// the (A + C) term.
//
// Parameters:
//   NUM_BYTES  bytes per operand word (2..8), word width = 8*NUM_BYTES
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      one-cycle pulse that begins a word (only honoured in IDLE)
//   in_valid   a_byte/b_byte carry a beat this cycle
//   in_ready   adder accepts a byte pair this cycle (state == RUN)
//   a_byte     operand A byte, LSB-first
//   b_byte     operand B byte, LSB-first
//   sum_byte   registered sum byte
//   sum_valid  one-cycle pulse per produced sum byte
//   sum_last   marks the final sum byte of the word
//   carry_out  final carry of the last completed word, held until next start
//   busy       word operation in progress
//
// Optional build macro SEED_ADDER_WORD_OUT_EN adds:
//   sum_word   whole-word result assembled from the sum bytes
//   word_valid pulses together with sum_last

module seed_serial_adder #(
    parameter int NUM_BYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               a_byte,
    input  logic [7:0]               b_byte,
    output logic [7:0]               sum_byte,
    output logic                     sum_valid,
    output logic                     sum_last,
    output logic                     carry_out,
`ifdef SEED_ADDER_WORD_OUT_EN
    output logic [8*NUM_BYTES-1:0]   sum_word,
    output logic                     word_valid,
`endif
    output logic                     busy
);

    localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state;
    logic          carry;
    logic [CW-1:0] count;

    logic          beat_accept;
    logic          beat_last;
    logic [8:0]    add_result;

    // A beat is only taken while running; in IDLE in_valid is ignored.
    assign in_ready    = (state == ST_RUN);
    assign busy        = (state == ST_RUN);
    assign beat_accept = in_valid && in_ready;
    assign beat_last   = (count == LAST_IDX);

    // Nine-bit sum: the top bit becomes the carry into the next byte.
    assign add_result  = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};

    // Control FSM, carry chain and byte outputs. Starting a word clears the
    // carry, the counter and the previous word's carry_out in the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            carry     <= 1'b0;
            count     <= '0;
            sum_byte  <= 8'd0;
            sum_valid <= 1'b0;
            sum_last  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            sum_last  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        carry     <= 1'b0;
                        count     <= '0;
                        carry_out <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (beat_accept) begin
                        sum_byte  <= add_result[7:0];
                        carry     <= add_result[8];
                        sum_valid <= 1'b1;
                        count     <= count + CW'(1);
                        if (beat_last) begin
                            sum_last  <= 1'b1;
                            carry_out <= add_result[8];
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SEED_ADDER_WORD_OUT_EN
    // Each new sum byte enters at the top, so after the last beat byte i
    // sits at bits 8i+7:8i. Older contents stay until the next word's
    // first byte pushes them out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_word   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= beat_accept && beat_last;
            if (beat_accept) begin
                sum_word <= {add_result[7:0], sum_word[8*NUM_BYTES-1:8]};
            end
        end
    end
`endif

endmodule

// File: tb/tb_seed_serial_adder.sv
// tb_seed_serial_adder
//
// Directed bench for seed_serial_adder (NUM_BYTES = 4). Inputs change one
// time unit after a rising edge and outputs are checked one time unit
// after the following edge. The optional word outputs are checked only
// when SEED_ADDER_WORD_OUT_EN is defined.

module tb_seed_serial_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic [7:0]  sum_byte;
    logic        sum_valid;
    logic        sum_last;
    logic        carry_out;
    logic        busy;
`ifdef SEED_ADDER_WORD_OUT_EN
    logic [31:0] sum_word;
    logic        word_valid;
`endif

    int num_asserts;
    int num_fails;

    seed_serial_adder #(.NUM_BYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_byte    (a_byte),
        .b_byte    (b_byte),
        .sum_byte  (sum_byte),
        .sum_valid (sum_valid),
        .sum_last  (sum_last),
        .carry_out (carry_out),
`ifdef SEED_ADDER_WORD_OUT_EN
        .sum_word  (sum_word),
        .word_valid(word_valid),
`endif
        .busy      (busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs, lets the edge happen, then idles inputs.
    task automatic applyStimulus(input logic st, input logic iv,
                                 input logic [7:0] a, input logic [7:0] b);
        start    = st;
        in_valid = iv;
        a_byte   = a;
        b_byte   = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        a_byte   = 8'd0;
        b_byte   = 8'd0;
    endtask

    // One counted comparison of an observed value against its expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        num_asserts++;
        assert (observed === expected)
        else begin
            num_fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks one produced sum byte together with its sum_last flag.
    task automatic checkByte(input string tag, input logic [7:0] exp_byte,
                             input logic exp_last);
        checkOutput({tag, "_valid"}, {63'd0, sum_valid}, 64'd1);
        checkOutput({tag, "_byte"},  {56'd0, sum_byte},  {56'd0, exp_byte});
        checkOutput({tag, "_last"},  {63'd0, sum_last},  {63'd0, exp_last});
    endtask

    initial begin
        num_asserts = 0;
        num_fails   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        a_byte   = 8'd0;
        b_byte   = 8'd0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_busy",      {63'd0, busy},      64'd0);
        checkOutput("rst_in_ready",  {63'd0, in_ready},  64'd0);
        checkOutput("rst_sum_valid", {63'd0, sum_valid}, 64'd0);
        checkOutput("rst_sum_byte",  {56'd0, sum_byte},  64'd0);
        checkOutput("rst_carry_out", {63'd0, carry_out}, 64'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

        // Basic add 0x12345678 + 0x11111111
        $display("[TB] basic add");
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("basic_busy",     {63'd0, busy},     64'd1);
        checkOutput("basic_in_ready", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b0, 1'b1, 8'h78, 8'h11);
        checkByte("basic_b0", 8'h89, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h56, 8'h11);
        checkByte("basic_b1", 8'h67, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h34, 8'h11);
        checkByte("basic_b2", 8'h45, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h12, 8'h11);
        checkByte("basic_b3", 8'h23, 1'b1);
        checkOutput("basic_carry", {63'd0, carry_out}, 64'd0);
        checkOutput("basic_busy_end", {63'd0, busy}, 64'd0);
`ifdef SEED_ADDER_WORD_OUT_EN
        checkOutput("basic_word",       {32'd0, sum_word},   64'h23456789);
        checkOutput("basic_word_valid", {63'd0, word_valid}, 64'd1);
`endif
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("basic_idle_valid", {63'd0, sum_valid}, 64'd0);
        checkOutput("basic_idle_last",  {63'd0, sum_last},  64'd0);

        // Full carry ripple 0xFFFFFFFF + 0x00000001
        $display("[TB] carry ripple");
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hFF, 8'h01);
        checkByte("ripple_b0", 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00);
        checkByte("ripple_b1", 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00);
        checkByte("ripple_b2", 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00);
        checkByte("ripple_b3", 8'h00, 1'b1);
        checkOutput("ripple_carry", {63'd0, carry_out}, 64'd1);
`ifdef SEED_ADDER_WORD_OUT_EN
        checkOutput("ripple_word", {32'd0, sum_word}, 64'h00000000);
`endif

        // Back-pressure: three idle cycles between beats 2 and 3
        $display("[TB] gaps");
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("gap_carry_cleared", {63'd0, carry_out}, 64'd0);
        applyStimulus(1'b0, 1'b1, 8'h78, 8'h11);
        checkByte("gap_b0", 8'h89, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h56, 8'h11);
        checkByte("gap_b1", 8'h67, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'hAA, 8'hBB);
            checkOutput("gap_no_valid", {63'd0, sum_valid}, 64'd0);
            checkOutput("gap_busy",     {63'd0, busy},      64'd1);
            checkOutput("gap_hold",     {56'd0, sum_byte},  64'h67);
        end
        applyStimulus(1'b0, 1'b1, 8'h34, 8'h11);
        checkByte("gap_b2", 8'h45, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h12, 8'h11);
        checkByte("gap_b3", 8'h23, 1'b1);

        // in_valid while idle is ignored
        $display("[TB] idle in_valid");
        applyStimulus(1'b0, 1'b1, 8'h55, 8'h55);
        checkOutput("idle_iv_valid0", {63'd0, sum_valid}, 64'd0);
        applyStimulus(1'b0, 1'b1, 8'h55, 8'h55);
        checkOutput("idle_iv_valid1", {63'd0, sum_valid}, 64'd0);
        checkOutput("idle_iv_busy",   {63'd0, busy},      64'd0);
        checkOutput("idle_iv_byte",   {56'd0, sum_byte},  64'h23);

        // start during a word is ignored; carry 0x80+0x80 crosses the restart
        $display("[TB] start mid-word");
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h80, 8'h80);
        checkByte("midstart_b0", 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h56, 8'h11);
        checkByte("midstart_b1", 8'h68, 1'b0);
        checkOutput("midstart_busy", {63'd0, busy}, 64'd1);
        applyStimulus(1'b0, 1'b1, 8'h34, 8'h11);
        checkByte("midstart_b2", 8'h45, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h12, 8'h11);
        checkByte("midstart_b3", 8'h23, 1'b1);
        checkOutput("midstart_carry", {63'd0, carry_out}, 64'd0);

        // Asynchronous reset in the middle of a word
        $display("[TB] reset mid-op");
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hFF, 8'h01);
        checkByte("rstmid_b0", 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00);
        checkByte("rstmid_b1", 8'h00, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_valid", {63'd0, sum_valid}, 64'd0);
        checkOutput("rstmid_last",  {63'd0, sum_last},  64'd0);
        checkOutput("rstmid_busy",  {63'd0, busy},      64'd0);
        checkOutput("rstmid_ready", {63'd0, in_ready},  64'd0);
        checkOutput("rstmid_byte",  {56'd0, sum_byte},  64'd0);
        checkOutput("rstmid_carry", {63'd0, carry_out}, 64'd0);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h01, 8'h01);
        checkByte("postrst_b0", 8'h02, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
        checkByte("postrst_b1", 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
        checkByte("postrst_b2", 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
        checkByte("postrst_b3", 8'h00, 1'b1);
        checkOutput("postrst_carry", {63'd0, carry_out}, 64'd0);

        // Back-to-back: 0x80000000 + 0x80000000, then start in sum_last cycle
        $display("[TB] back-to-back");
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h80, 8'h80);
        checkByte("b2b_first_b3", 8'h00, 1'b1);
        checkOutput("b2b_first_carry", {63'd0, carry_out}, 64'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("b2b_busy",         {63'd0, busy},      64'd1);
        checkOutput("b2b_carry_clear",  {63'd0, carry_out}, 64'd0);
        checkOutput("b2b_valid_drop",   {63'd0, sum_valid}, 64'd0);
        applyStimulus(1'b0, 1'b1, 8'h01, 8'h02);
        checkByte("b2b_b0", 8'h03, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
        checkByte("b2b_b1", 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
        checkByte("b2b_b2", 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
        checkByte("b2b_b3", 8'h00, 1'b1);
        checkOutput("b2b_carry", {63'd0, carry_out}, 64'd0);
`ifdef SEED_ADDER_WORD_OUT_EN
        checkOutput("b2b_word", {32'd0, sum_word}, 64'h00000003);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fails);
        $finish;
    end

endmodule

// File: doc/seed_serial_adder.md
Name: seed_serial_adder

Overview:
- Byte-serial 32-bit modular adder for the 8-bit SEED datapath.
- Counterpart of the byte-serial subtractor: computes A + B mod 2^32 instead of A - B, with a carry chain in place of the borrow chain.
- Used in the key schedule for the (A + C) term before constant subtraction.
- Operands enter LSB-first, one byte pair per accepted beat. The carry is held in a flop between beats, and one sum byte is produced per beat.

Parameters:
- NUM_BYTES, 4, bytes per operand word; legal range 2..8; word width = 8*NUM_BYTES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a new word operation (accepted only in IDLE)
- in_valid  input  1  a_byte/b_byte valid this cycle
- in_ready  output  1  block accepts a byte pair this cycle
- a_byte  input  8  operand A byte, LSB-first
- b_byte  input  8  operand B byte, LSB-first
- sum_byte  output  8  registered sum byte
- sum_valid  output  1  sum_byte valid (one-cycle pulse per beat)
- sum_last  output  1  qualifies the final sum byte of the word (only with sum_valid)
- carry_out  output  1  final carry of the last completed word; held until next start
- busy  output  1  operation in progress (state == RUN)

Behaviour:
- Reset (async, rst=1): state=IDLE; carry flop=0; byte counter=0. All outputs are 0, including carry_out and sum_byte.
- FSM states:
  - IDLE: in_ready=0, busy=0.
    - start=1 -> RUN next cycle.
    - On entry to RUN, carry flop=0 and counter=0 are set in the same edge.
    - in_valid is ignored in IDLE.
  - RUN: in_ready=1, busy=1.
    - A beat is accepted when in_valid & in_ready.
    - On an accepted beat: {c, s} = a_byte + b_byte + carry (9-bit sum). sum_byte<=s, carry<=c, sum_valid<=1, counter<=counter+1.
    - sum_last<=1 iff counter==NUM_BYTES-1.
    - On the last beat: carry_out<=c and state<=IDLE.
    - No accepted beat: sum_valid<=0, sum_last<=0, all else held. Gaps of any length are allowed.
- Latency:
  - Sum byte appears one cycle after its accepting edge.
  - Full word: NUM_BYTES accepted beats + 1 cycle.
  - start-to-first-acceptance is at least 1 cycle; in_ready rises the cycle after start.
- Back-to-back words: start may be asserted in the same cycle the last sum byte is presented (state is already IDLE). Maximum throughput is NUM_BYTES+1 cycles per word.
- start while in RUN: ignored; no restart, carry unaffected.
- Wrap-around: the result is modulo 2^(8*NUM_BYTES). The overflow is visible only on carry_out.
- carry_out is cleared to 0 on entry to RUN and updated only on the last beat.
- sum_valid and sum_last are never 1 in IDLE, except in the single cycle after the last beat.
- Reset mid-operation: immediate return to IDLE with all registers cleared. The partial word is discarded and no sum_last is emitted.

Optional Feature:
- Macro: SEED_ADDER_WORD_OUT_EN.
- Defined:
  - Adds output sum_word [8*NUM_BYTES-1:0], which shifts each new sum byte in from the top (byte i lands at bits 8i+7:8i).
  - Adds output word_valid (1 bit), which pulses in the same cycle as sum_last.
  - sum_word holds its value until the next word's first byte; it is reset to 0.
- Not defined: neither port exists, and the shift register is not synthesized. The byte-serial ports behave identically in both builds.

Test Plan:
- Basic add: start; A=0x12345678, B=0x11111111 streamed 78/11, 56/11, 34/11, 12/11 with no gaps -> sum bytes 89, 67, 45, 23; sum_last on 0x23; carry_out=0; busy deasserts after the 4th beat (word option: sum_word=0x23456789).
- Full carry ripple: A=0xFFFFFFFF, B=0x00000001 -> sum bytes 00, 00, 00, 00; carry_out=1.
- Back-pressure gaps: same operands as basic add, with in_valid low for 3 cycles between beats 2 and 3 -> identical sum bytes; no sum_valid during gaps; carry preserved across the gap.
- Reset mid-op: after 2 beats of 0xFFFFFFFF+0x00000001, pulse rst asynchronously -> all outputs 0 immediately.
  - Then a new word 0x00000001+0x00000001 -> 02, 00, 00, 00; carry_out=0 (no stale carry).
- Ignored events:
  - in_valid pulses in IDLE -> no sum_valid.
  - start asserted at beat 2 of a word -> the result is unchanged.
- Back-to-back: start asserted in the sum_last cycle of 0x80000000+0x80000000 (carry_out=1) -> the next word 0x00000001+0x00000002 produces 03, 00, 00, 00 and clears carry_out to 0.
